mcpu_ctrl: RTL and testbench
============================

# mcpu_ctrl

Multi-cycle control unit for the RV32I-subset CPU: a Moore-style FSM that sequences the shared datapath one instruction at a time. Each step drives the single ALU, the single memory port, the PC, the IR and the register file. It decodes the instruction held in the datapath IR (OPcode/Fun3/Fun7) and stalls on the memory handshake `MIO_ready`. It supports the same instruction set and ALU_Control/ImmSel encodings as the single-cycle controller. It sits between the IR and the multi-cycle datapath muxes.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `OPcode`  in  5  IR[6:2]
- `Fun3`  in  3  IR[14:12]
- `Fun7`  in  1  IR[30]
- `zero`  in  1  ALU zero flag, same cycle
- `MIO_ready`  in  1  memory access completes this cycle
- `MemReq`  out  1  memory access request
- `MemRW`  out  1  1 = write
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `IRWrite`  out  1  load IR and OldPC
- `PCWrite`  out  1  load PC
- `PCSource`  out  2  PC input: 00 = ALU result, 01 = ALUOut
- `RegWrite`  out  1  register file write
- `MemtoReg`  out  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC (already PC+4), 11 = imm
- `ALUSrcA`  out  2  ALU A input: 00 = PC, 01 = rs1, 10 = OldPC
- `ALUSrcB`  out  2  ALU B input: 00 = rs2, 01 = 4, 10 = imm
- `ALU_Control`  out  4  and 0000, or 0001, add 0010, sub 0110, slt 0111, sltu 1001, xor 1100, srl 1101, sll 1110, sra 1111
- `ImmSel`  out  3  U 000, I 001, S 010, B 011, J 100
- `Branch`, `BranchN`  out  1 each  beq / bne in progress
- `illegal`  out  1  one-cycle pulse on an undecodable instruction
- `state`  out  4  current state, for debug

## Operation
- Outputs default to 0 in every state. Only the signals listed below are non-zero.
- FETCH (0):
  - drives MemReq=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALU add.
  - IRWrite=PCWrite=MIO_ready.
  - Stays in FETCH while MIO_ready=0; moves to DECODE when MIO_ready=1.
- DECODE (1):
  - drives ALUSrcA=10, ALUSrcB=10, add; ImmSel = B for opcode 11000, J otherwise. The branch/jal target is latched into ALUOut.
  - Next state by OPcode: 01100 → EXE_R, 00100 → EXE_I, 00000/01000 → MEM_ADDR, 11000 → BRANCH, 11011 → JAL, 11001 → JALR, 01101 → LUI, anything else → ILLEGAL.
- EXE_R (2): ALUSrcA=01, ALUSrcB=00, ALU_Control from {Fun3,Fun7}. An unlisted {Fun3,Fun7} goes to ILLEGAL; otherwise → ALU_WB.
- EXE_I (3):
  - ALUSrcA=01, ALUSrcB=10, ImmSel=I, ALU_Control from Fun3.
  - Fun3=101 selects srl or sra by Fun7.
  - Fun3=001 with Fun7=1 → ILLEGAL; otherwise → ALU_WB.
- ALU_WB (4): RegWrite, MemtoReg=00 → FETCH.
- MEM_ADDR (5): ALUSrcA=01, ALUSrcB=10, add, ImmSel = I for load, S for store. Next: load → MEM_RD, store → MEM_WR.
- MEM_RD (6): MemReq, IorD=1; waits for MIO_ready, then → LD_WB.
- LD_WB (7): RegWrite, MemtoReg=01 → FETCH.
- MEM_WR (8): MemReq, MemRW=1, IorD=1; waits for MIO_ready, then → FETCH.
- BRANCH (9):
  - ALUSrcA=01, ALUSrcB=00, sub, PCSource=01.
  - Fun3=000: Branch=1, PCWrite=zero. Fun3=001: BranchN=1, PCWrite=~zero.
  - Other Fun3 → ILLEGAL with no PCWrite; otherwise → FETCH.
- JAL (10): RegWrite, MemtoReg=10, PCWrite, PCSource=01 → FETCH.
- JALR (11):
  - ALUSrcA=01, ALUSrcB=10, ImmSel=I, add, PCSource=00, PCWrite, RegWrite, MemtoReg=10 → FETCH.
  - The register write uses the pre-edge PC. Clearing bit 0 of the target is the datapath's job.
- LUI (12): RegWrite, MemtoReg=11, ImmSel=U → FETCH.
- ILLEGAL (15): illegal=1 with no writes → FETCH. The instruction is skipped because PC was already advanced.
- Encodings 13–14 are unreachable and recover to FETCH on the next edge.

## Timing
- While rst_n=0: state=FETCH(0) and every output is 0, gated combinationally so MemReq/PCWrite/RegWrite drop immediately.
- Reset asserted mid-instruction: the partial instruction is abandoned.
- After rst_n rises: FETCH drives its normal outputs.
- Outputs are a function of state, plus MIO_ready/zero/Fun fields where stated; the state register has one edge of latency.
- Cycles per instruction with a zero-wait memory (MIO_ready=1):
  - R/I-ALU 4, load 5, store 4
  - branch 3, jal 3, jalr 3, lui 3, illegal 3
- Each MIO_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle. Requests are held stable while waiting.
- MIO_ready is ignored in states that have no MemReq.

## Test plan
- Reset: pulse rst_n low mid-MEM_WR → MemReq/MemRW fall to 0 in the same cycle; state=0 after release; first fetch at the next edge.
- add x3,x1,x2 with MIO_ready=1: states 0,1,2,4 → exactly one RegWrite, in cycle 4, ALU_Control=0010 in EXE_R; sub gives 0110, sra gives 1111.
- lw with MIO_ready low for 2 cycles in MEM_RD: states 0,1,5,6,6,6,7 → MemReq high for all three MEM_RD cycles; RegWrite with MemtoReg=01 in LD_WB; total 7 cycles.
- beq with zero=1 → PCWrite=1, PCSource=01, Branch=1; bne with zero=1 → PCWrite=0, BranchN=1; both take 3 cycles.
- jal / jalr / lui → RegWrite in the third cycle with MemtoReg 10/10/11; PCSource 01/00/–.
- OPcode=11111, and R-type {Fun3,Fun7}=0011 → illegal pulses for 1 cycle; no RegWrite/MemReq beyond fetch; next state FETCH.

Source files
------------

// File: rtl/mcpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_ctrl
//  Description : Multi-cycle control FSM for the RV32I-subset CPU. Sequences
//                the shared ALU, memory port, PC, IR and register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcpu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       MemReq,
    output logic       MemRW,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       RegWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALU_Control,
    output logic [2:0] ImmSel,
    output logic       Branch,
    output logic       BranchN,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXE_R    = 4'd2,
        S_EXE_I    = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_LD_WB    = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;
    localparam logic [3:0] c_ALU_SLTU = 4'b1001;
    localparam logic [3:0] c_ALU_XOR  = 4'b1100;
    localparam logic [3:0] c_ALU_SRL  = 4'b1101;
    localparam logic [3:0] c_ALU_SLL  = 4'b1110;
    localparam logic [3:0] c_ALU_SRA  = 4'b1111;

    localparam logic [2:0] c_IMM_U = 3'b000;
    localparam logic [2:0] c_IMM_I = 3'b001;
    localparam logic [2:0] c_IMM_S = 3'b010;
    localparam logic [2:0] c_IMM_B = 3'b011;
    localparam logic [2:0] c_IMM_J = 3'b100;

    localparam logic [4:0] c_OP_R      = 5'b01100;
    localparam logic [4:0] c_OP_I      = 5'b00100;
    localparam logic [4:0] c_OP_LOAD   = 5'b00000;
    localparam logic [4:0] c_OP_STORE  = 5'b01000;
    localparam logic [4:0] c_OP_BRANCH = 5'b11000;
    localparam logic [4:0] c_OP_JAL    = 5'b11011;
    localparam logic [4:0] c_OP_JALR   = 5'b11001;
    localparam logic [4:0] c_OP_LUI    = 5'b01101;

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign state = r_state;

    // Outputs are forced low while reset is held so writes stop without waiting for a clock.
    always_comb begin
        w_next_state = S_FETCH;
        MemReq       = 1'b0;
        MemRW        = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCSource     = 2'b00;
        RegWrite     = 1'b0;
        MemtoReg     = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALU_Control  = 4'b0000;
        ImmSel       = 3'b000;
        Branch       = 1'b0;
        BranchN      = 1'b0;
        illegal      = 1'b0;

        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    MemReq      = 1'b1;
                    ALUSrcB     = 2'b01;
                    ALU_Control = c_ALU_ADD;
                    IRWrite     = MIO_ready;
                    PCWrite     = MIO_ready;
                    w_next_state = MIO_ready ? S_DECODE : S_FETCH;
                end

                S_DECODE: begin
                    ALUSrcA     = 2'b10;
                    ALUSrcB     = 2'b10;
                    ALU_Control = c_ALU_ADD;
                    ImmSel      = (OPcode == c_OP_BRANCH) ? c_IMM_B : c_IMM_J;
                    case (OPcode)
                        c_OP_R:      w_next_state = S_EXE_R;
                        c_OP_I:      w_next_state = S_EXE_I;
                        c_OP_LOAD:   w_next_state = S_MEM_ADDR;
                        c_OP_STORE:  w_next_state = S_MEM_ADDR;
                        c_OP_BRANCH: w_next_state = S_BRANCH;
                        c_OP_JAL:    w_next_state = S_JAL;
                        c_OP_JALR:   w_next_state = S_JALR;
                        c_OP_LUI:    w_next_state = S_LUI;
                        default:     w_next_state = S_ILLEGAL;
                    endcase
                end

                S_EXE_R: begin
                    ALUSrcA      = 2'b01;
                    ALUSrcB      = 2'b00;
                    w_next_state = S_ALU_WB;
                    case ({Fun3, Fun7})
                        4'b0000: ALU_Control = c_ALU_ADD;
                        4'b0001: ALU_Control = c_ALU_SUB;
                        4'b0010: ALU_Control = c_ALU_SLL;
                        4'b0100: ALU_Control = c_ALU_SLT;
                        4'b0110: ALU_Control = c_ALU_SLTU;
                        4'b1000: ALU_Control = c_ALU_XOR;
                        4'b1010: ALU_Control = c_ALU_SRL;
                        4'b1011: ALU_Control = c_ALU_SRA;
                        4'b1100: ALU_Control = c_ALU_OR;
                        4'b1110: ALU_Control = c_ALU_AND;
                        default: w_next_state = S_ILLEGAL;
                    endcase
                end

                S_EXE_I: begin
                    ALUSrcA      = 2'b01;
                    ALUSrcB      = 2'b10;
                    ImmSel       = c_IMM_I;
                    w_next_state = S_ALU_WB;
                    case (Fun3)
                        3'b000: ALU_Control = c_ALU_ADD;
                        3'b001: begin
                            ALU_Control = c_ALU_SLL;
                            if (Fun7) begin
                                w_next_state = S_ILLEGAL;
                            end
                        end
                        3'b010: ALU_Control = c_ALU_SLT;
                        3'b011: ALU_Control = c_ALU_SLTU;
                        3'b100: ALU_Control = c_ALU_XOR;
                        3'b101: ALU_Control = Fun7 ? c_ALU_SRA : c_ALU_SRL;
                        3'b110: ALU_Control = c_ALU_OR;
                        default: ALU_Control = c_ALU_AND;
                    endcase
                end

                S_ALU_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b00;
                end

                // Only loads and stores reach here; OPcode[3] separates them.
                S_MEM_ADDR: begin
                    ALUSrcA      = 2'b01;
                    ALUSrcB      = 2'b10;
                    ALU_Control  = c_ALU_ADD;
                    ImmSel       = OPcode[3] ? c_IMM_S : c_IMM_I;
                    w_next_state = OPcode[3] ? S_MEM_WR : S_MEM_RD;
                end

                S_MEM_RD: begin
                    MemReq       = 1'b1;
                    IorD         = 1'b1;
                    w_next_state = MIO_ready ? S_LD_WB : S_MEM_RD;
                end

                S_LD_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end

                S_MEM_WR: begin
                    MemReq       = 1'b1;
                    MemRW        = 1'b1;
                    IorD         = 1'b1;
                    w_next_state = MIO_ready ? S_FETCH : S_MEM_WR;
                end

                S_BRANCH: begin
                    ALUSrcA     = 2'b01;
                    ALUSrcB     = 2'b00;
                    ALU_Control = c_ALU_SUB;
                    PCSource    = 2'b01;
                    case (Fun3)
                        3'b000: begin
                            Branch  = 1'b1;
                            PCWrite = zero;
                        end
                        3'b001: begin
                            BranchN = 1'b1;
                            PCWrite = ~zero;
                        end
                        default: w_next_state = S_ILLEGAL;
                    endcase
                end

                // Target was latched into ALUOut during DECODE.
                S_JAL: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b10;
                    PCWrite  = 1'b1;
                    PCSource = 2'b01;
                end

                S_JALR: begin
                    ALUSrcA     = 2'b01;
                    ALUSrcB     = 2'b10;
                    ImmSel      = c_IMM_I;
                    ALU_Control = c_ALU_ADD;
                    PCSource    = 2'b00;
                    PCWrite     = 1'b1;
                    RegWrite    = 1'b1;
                    MemtoReg    = 2'b10;
                end

                S_LUI: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b11;
                    ImmSel   = c_IMM_U;
                end

                S_ILLEGAL: begin
                    illegal = 1'b1;
                end

                default: w_next_state = S_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcpu_ctrl
//  Description : Scoreboard bench for mcpu_ctrl; per-cycle expected outputs
//                are queued per instruction and compared as the FSM advances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcpu_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       zero;
    logic       MIO_ready;
    logic       MemReq, MemRW, IorD, IRWrite, PCWrite, RegWrite;
    logic [1:0] PCSource, MemtoReg, ALUSrcA, ALUSrcB;
    logic [3:0] ALU_Control;
    logic [2:0] ImmSel;
    logic       Branch, BranchN, illegal;
    logic [3:0] state;

    mcpu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
        .zero(zero), .MIO_ready(MIO_ready), .MemReq(MemReq), .MemRW(MemRW),
        .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control), .ImmSel(ImmSel),
        .Branch(Branch), .BranchN(BranchN), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mrw, iord, irw, pcw;
        logic [1:0] pcsrc;
        logic       rw;
        logic [1:0] m2r, asa, asb;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       br, brn, ill;
    } out_t;

    typedef struct packed {
        logic rdy;
        logic z;
        out_t exp;
    } step_t;

    out_t  w_obs;
    step_t q[$];
    int    checks = 0;
    int    errors = 0;

    assign w_obs = {state, MemReq, MemRW, IorD, IRWrite, PCWrite, PCSource, RegWrite,
                    MemtoReg, ALUSrcA, ALUSrcB, ALU_Control, ImmSel, Branch, BranchN, illegal};

    // Expected per-state outputs, written directly from the control table.
    function automatic out_t o_fetch(input logic rdy);
        out_t o = '0;
        o.st = 4'd0; o.mreq = 1'b1; o.asb = 2'b01; o.alu = 4'b0010;
        o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction
    function automatic out_t o_decode(input logic is_br);
        out_t o = '0;
        o.st = 4'd1; o.asa = 2'b10; o.asb = 2'b10; o.alu = 4'b0010;
        o.imm = is_br ? 3'b011 : 3'b100;
        return o;
    endfunction
    function automatic out_t o_exe_r(input logic [3:0] alu);
        out_t o = '0;
        o.st = 4'd2; o.asa = 2'b01; o.alu = alu;
        return o;
    endfunction
    function automatic out_t o_exe_i(input logic [3:0] alu);
        out_t o = '0;
        o.st = 4'd3; o.asa = 2'b01; o.asb = 2'b10; o.imm = 3'b001; o.alu = alu;
        return o;
    endfunction
    function automatic out_t o_wb(input logic [3:0] st, input logic [1:0] m2r);
        out_t o = '0;
        o.st = st; o.rw = 1'b1; o.m2r = m2r;
        return o;
    endfunction
    function automatic out_t o_mem_addr(input logic store);
        out_t o = '0;
        o.st = 4'd5; o.asa = 2'b01; o.asb = 2'b10; o.alu = 4'b0010;
        o.imm = store ? 3'b010 : 3'b001;
        return o;
    endfunction
    function automatic out_t o_mem(input logic wr);
        out_t o = '0;
        o.st = wr ? 4'd8 : 4'd6; o.mreq = 1'b1; o.mrw = wr; o.iord = 1'b1;
        return o;
    endfunction
    function automatic out_t o_branch(input logic bne, input logic pcw);
        out_t o = '0;
        o.st = 4'd9; o.asa = 2'b01; o.alu = 4'b0110; o.pcsrc = 2'b01;
        o.br = ~bne; o.brn = bne; o.pcw = pcw;
        return o;
    endfunction
    function automatic out_t o_jal();
        out_t o = '0;
        o.st = 4'd10; o.rw = 1'b1; o.m2r = 2'b10; o.pcw = 1'b1; o.pcsrc = 2'b01;
        return o;
    endfunction
    function automatic out_t o_jalr();
        out_t o = '0;
        o.st = 4'd11; o.asa = 2'b01; o.asb = 2'b10; o.imm = 3'b001; o.alu = 4'b0010;
        o.pcw = 1'b1; o.rw = 1'b1; o.m2r = 2'b10;
        return o;
    endfunction
    function automatic out_t o_lui();
        out_t o = '0;
        o.st = 4'd12; o.rw = 1'b1; o.m2r = 2'b11; o.imm = 3'b000;
        return o;
    endfunction
    function automatic out_t o_ill();
        out_t o = '0;
        o.st = 4'd15; o.ill = 1'b1;
        return o;
    endfunction

    task automatic push(input logic rdy, input logic z, input out_t e);
        step_t s;
        s.rdy = rdy; s.z = z; s.exp = e;
        q.push_back(s);
    endtask

    // Entered just after a rising edge; one queued step is consumed per cycle.
    task automatic run(input string name, input logic [4:0] op, input logic [2:0] f3, input logic f7);
        step_t s;
        int    n = 0;
        OPcode = op; Fun3 = f3; Fun7 = f7;
        while (q.size() > 0) begin
            s = q.pop_front();
            MIO_ready = s.rdy;
            zero      = s.z;
            @(negedge clk);
            checks++;
            if (w_obs !== s.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, n, w_obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; MIO_ready = 1'b1; zero = 1'b0;
        OPcode = 5'b01100; Fun3 = 3'b000; Fun7 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (w_obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", w_obs, out_t'('0));
        end
        MIO_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (w_obs !== o_fetch(1'b0)) begin
            errors++;
            $display("FAIL reset_release_fetch: got %h expected %h", w_obs, o_fetch(1'b0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_r_type();
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0));
        push(1, 0, o_exe_r(4'b0010)); push(1, 0, o_wb(4'd4, 2'b00));
        run("add", 5'b01100, 3'b000, 1'b0);
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0));
        push(1, 0, o_exe_r(4'b0110)); push(1, 0, o_wb(4'd4, 2'b00));
        run("sub", 5'b01100, 3'b000, 1'b1);
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0));
        push(1, 0, o_exe_r(4'b1111)); push(1, 0, o_wb(4'd4, 2'b00));
        run("sra", 5'b01100, 3'b101, 1'b1);
    endtask

    task automatic test_i_type();
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0));
        push(1, 0, o_exe_i(4'b1101)); push(1, 0, o_wb(4'd4, 2'b00));
        run("srli", 5'b00100, 3'b101, 1'b0);
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0));
        push(1, 0, o_exe_i(4'b1001)); push(1, 0, o_wb(4'd4, 2'b00));
        run("sltiu", 5'b00100, 3'b011, 1'b0);
    endtask

    task automatic test_load_store();
        push(0, 0, o_fetch(0)); push(1, 0, o_fetch(1)); push(0, 0, o_decode(0));
        push(1, 0, o_mem_addr(0));
        push(0, 0, o_mem(0)); push(0, 0, o_mem(0)); push(1, 0, o_mem(0));
        push(1, 0, o_wb(4'd7, 2'b01));
        run("lw_wait", 5'b00000, 3'b010, 1'b0);
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0));
        push(1, 0, o_mem_addr(1)); push(1, 0, o_mem(1));
        run("sw", 5'b01000, 3'b010, 1'b0);
    endtask

    task automatic test_branch();
        push(1, 1, o_fetch(1)); push(1, 1, o_decode(1)); push(1, 1, o_branch(0, 1));
        run("beq_taken", 5'b11000, 3'b000, 1'b0);
        push(1, 1, o_fetch(1)); push(1, 1, o_decode(1)); push(1, 1, o_branch(1, 0));
        run("bne_not_taken", 5'b11000, 3'b001, 1'b0);
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(1)); push(1, 0, o_branch(1, 1));
        run("bne_taken", 5'b11000, 3'b001, 1'b0);
    endtask

    task automatic test_jumps();
        push(1, 0, o_fetch(1)); push(0, 0, o_decode(0)); push(0, 0, o_jal());
        run("jal", 5'b11011, 3'b000, 1'b0);
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0)); push(1, 0, o_jalr());
        run("jalr", 5'b11001, 3'b000, 1'b0);
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0)); push(1, 0, o_lui());
        run("lui", 5'b01101, 3'b000, 1'b0);
    endtask

    task automatic test_illegal();
        out_t e;
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0)); push(1, 0, o_ill());
        run("ill_opcode", 5'b11111, 3'b000, 1'b0);
        e = o_exe_r(4'b0000);
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0)); push(1, 0, e); push(1, 0, o_ill());
        push(0, 0, o_fetch(0));
        run("ill_r_fun", 5'b01100, 3'b001, 1'b1);
    endtask

    task automatic test_reset_mid();
        push(1, 0, o_fetch(1)); push(1, 0, o_decode(0));
        push(1, 0, o_mem_addr(1)); push(0, 0, o_mem(1));
        run("sw_stall", 5'b01000, 3'b010, 1'b0);
        #2;
        checks++;
        if (state !== 4'd8 || MemReq !== 1'b1 || MemRW !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre: got state=%0d MemReq=%b MemRW=%b expected 8 1 1",
                     state, MemReq, MemRW);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (MemReq !== 1'b0 || MemRW !== 1'b0 || w_obs !== '0) begin
            errors++;
            $display("FAIL mid_reset_drop: got %h expected %h", w_obs, out_t'('0));
        end
        @(negedge clk);
        MIO_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (w_obs !== o_fetch(1'b1)) begin
            errors++;
            $display("FAIL mid_reset_release: got %h expected %h", w_obs, o_fetch(1'b1));
        end
        @(posedge clk);
        #1;
        push(1, 0, o_decode(0)); push(1, 0, o_lui()); push(0, 0, o_fetch(0));
        run("after_reset", 5'b01101, 3'b000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_load_store();
        test_branch();
        test_jumps();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
